// File: rtl/load_mem_unit_pkg.sv
// Shared types and constants for the load memory unit.
//  load_state_e    : FSM state encoding of the load responder
//  cdb_req_s       : result bundle presented to the CDB arbiter, laid out so it
//                    merges field-for-field with the arbiter's packed request
//  is_word_aligned : true when a byte address sits on a 32-bit word boundary
package load_mem_unit_pkg;

  localparam int LMU_TAG_W   = 4;
  localparam int LMU_ADDR_W  = 32;
  localparam int LMU_DATA_W  = 32;
  localparam int LMU_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_REQ  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_CDB_REQ  = 3'd3,
    ST_DRAIN    = 3'd4
  } load_state_e;

  typedef struct packed {
    logic                  valid;
    logic [LMU_TAG_W-1:0]  rob_tag;
    logic [LMU_DATA_W-1:0] data;
    logic                  err;
  } cdb_req_s;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/load_mem_unit.sv
// Load memory unit: responder for the head of the RS load queue.
// Takes one load at a time, issues a single word read to data memory, and
// presents the result (or an error for misaligned / timed-out loads) to the
// CDB arbiter. On grant it pulses clear_load so the RS pops the head entry.
// A mispredict flush (recover_en) aborts the load; an already-issued memory
// read is drained so its data can never be forwarded.
// Ports:
//  clk_i, reset_ni          clock, synchronous active-low reset
//  recover_en               flush the in-flight load
//  load_req_*               RS load-queue head (valid, ROB tag, byte address)
//  clear_load               one-cycle pop strobe back to the RS
//  mem_req_*/mem_rsp_*      data-memory read request / response
//  cdb_req_*, cdb_grant     result request to the CDB arbiter and its grant
//  busy                     unit is not idle
module load_mem_unit
  import load_mem_unit_pkg::*;
#(
  parameter int TAG_W   = LMU_TAG_W,
  parameter int ADDR_W  = LMU_ADDR_W,
  parameter int DATA_W  = LMU_DATA_W,
  parameter int TIMEOUT = LMU_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              recover_en,
  input  logic              load_req_valid,
  input  logic [TAG_W-1:0]  load_req_rob_addr,
  input  logic [ADDR_W-1:0] load_req_addr,
  output logic              clear_load,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              cdb_req_valid,
  output logic [TAG_W-1:0]  cdb_req_rob_tag,
  output logic [DATA_W-1:0] cdb_req_data,
  output logic              cdb_req_err,
  input  logic              cdb_grant,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  load_state_e       state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    // Free-running saturating counter; only meaningful in MEM_WAIT and DRAIN,
    // where it is cleared on entry.
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!recover_en && load_req_valid) begin
          tag_d  = load_req_rob_addr;
          addr_d = load_req_addr;
          data_d = '0;
          if (is_word_aligned(load_req_addr[1:0])) begin
            err_d   = 1'b0;
            state_d = ST_MEM_REQ;
          end else begin
            // Misaligned loads skip memory and report an error directly.
            err_d   = 1'b1;
            state_d = ST_CDB_REQ;
          end
        end
      end
      ST_MEM_REQ: begin
        // Once the read is accepted a response is owed, so a flush at that
        // point must go through DRAIN rather than straight to IDLE.
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = recover_en ? ST_DRAIN : ST_MEM_WAIT;
        end else if (recover_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (recover_en) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          err_d   = 1'b0;
          state_d = ST_CDB_REQ;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_CDB_REQ;
        end
      end
      ST_CDB_REQ: begin
        if (recover_en || cdb_grant) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid || (cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by state so every interface is quiet outside its phase.
  always_comb begin
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    cdb_req_valid   = 1'b0;
    cdb_req_rob_tag = '0;
    cdb_req_data    = '0;
    cdb_req_err     = 1'b0;
    clear_load      = 1'b0;
    busy            = (state_q != ST_IDLE);

    if (state_q == ST_MEM_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = addr_q & WORD_MASK;
    end

    if (state_q == ST_CDB_REQ) begin
      cdb_req_valid   = 1'b1;
      cdb_req_rob_tag = tag_q;
      cdb_req_data    = data_q;
      cdb_req_err     = err_q;
      // A flush in the grant cycle drops the result, so the RS must not pop.
      clear_load      = cdb_grant && !recover_en;
    end
  end

endmodule

// File: tb/tb_load_mem_unit.sv
// Self-checking bench for load_mem_unit. Each load is driven cycle by cycle
// and its CDB result is compared against a transaction-level reference that
// only knows the rules: misaligned or unanswered loads return err=1/data=0,
// everything else returns the memory word.
module tb_load_mem_unit;

  localparam int TAG_W   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              recover_en;
  logic              load_req_valid;
  logic [TAG_W-1:0]  load_req_rob_addr;
  logic [ADDR_W-1:0] load_req_addr;
  logic              clear_load;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              cdb_req_valid;
  logic [TAG_W-1:0]  cdb_req_rob_tag;
  logic [DATA_W-1:0] cdb_req_data;
  logic              cdb_req_err;
  logic              cdb_grant;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  load_mem_unit #(
    .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .recover_en(recover_en),
    .load_req_valid(load_req_valid),
    .load_req_rob_addr(load_req_rob_addr),
    .load_req_addr(load_req_addr),
    .clear_load(clear_load),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .cdb_req_valid(cdb_req_valid),
    .cdb_req_rob_tag(cdb_req_rob_tag),
    .cdb_req_data(cdb_req_data),
    .cdb_req_err(cdb_req_err),
    .cdb_grant(cdb_grant),
    .busy(busy)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge, outputs are sampled 1ns later.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    recover_en        = 1'b0;
    load_req_valid    = 1'b0;
    load_req_rob_addr = '0;
    load_req_addr     = '0;
    mem_req_ready     = 1'b0;
    mem_rsp_valid     = 1'b0;
    mem_rsp_data      = '0;
    cdb_grant         = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_memreq"}, mem_req_valid, 0);
    check_output({tag, "_memaddr"}, mem_req_addr, 0);
    check_output({tag, "_cdbvalid"}, cdb_req_valid, 0);
    check_output({tag, "_cdbtag"}, cdb_req_rob_tag, 0);
    check_output({tag, "_cdbdata"}, cdb_req_data, 0);
    check_output({tag, "_cdberr"}, cdb_req_err, 0);
    check_output({tag, "_clear"}, clear_load, 0);
  endtask

  // Reference result {err, data}: an error wins over any data.
  function automatic logic [32:0] ref_result(input logic [31:0] addr, input logic [31:0] rdata,
                                             input int rsp_lat);
    bit misaligned = (addr % 4) != 0;
    bit timed_out  = rsp_lat >= TIMEOUT;
    if (misaligned || timed_out) return {1'b1, 32'h0};
    return {1'b0, rdata};
  endfunction

  // One complete load. ready_lat/rsp_lat/grant_lat are the number of idle
  // cycles before each handshake; rsp_lat >= TIMEOUT means memory never answers.
  task automatic apply_load(input logic [3:0] tag, input logic [31:0] addr, input int ready_lat,
                            input int rsp_lat, input int grant_lat, input logic [31:0] rdata);
    logic [32:0] exp;
    int clears;
    exp    = ref_result(addr, rdata, rsp_lat);
    clears = 0;
    load_req_valid    = 1'b1;
    load_req_rob_addr = tag;
    load_req_addr     = addr;
    settle();
    check_output("idle_busy", busy, 0);
    check_output("idle_memreq", mem_req_valid, 0);
    cycle();
    if (addr[1:0] == 2'b00) begin
      for (int i = 0; i <= ready_lat; i++) begin
        mem_req_ready = (i == ready_lat);
        settle();
        check_output("memreq_valid", mem_req_valid, 1);
        check_output("memreq_addr", mem_req_addr, {addr[31:2], 2'b00});
        check_output("memreq_nocdb", cdb_req_valid, 0);
        cycle();
      end
      mem_req_ready = 1'b0;
      if (rsp_lat < TIMEOUT) begin
        for (int j = 0; j <= rsp_lat; j++) begin
          mem_rsp_valid = (j == rsp_lat);
          mem_rsp_data  = (j == rsp_lat) ? rdata : $urandom;
          settle();
          check_output("wait_nocdb", cdb_req_valid, 0);
          check_output("wait_nomemreq", mem_req_valid, 0);
          cycle();
        end
      end else begin
        for (int j = 0; j < TIMEOUT; j++) begin
          settle();
          check_output("timeout_nocdb", cdb_req_valid, 0);
          cycle();
        end
      end
      mem_rsp_valid = 1'b0;
    end
    for (int k = 0; k <= grant_lat; k++) begin
      cdb_grant = (k == grant_lat);
      // A response arriving after the timeout must not change the result.
      if (rsp_lat >= TIMEOUT && k == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rdata ^ 32'hFFFF_FFFF;
      end
      settle();
      check_output("cdb_valid", cdb_req_valid, 1);
      check_output("cdb_tag", cdb_req_rob_tag, tag);
      check_output("cdb_data", cdb_req_data, exp[31:0]);
      check_output("cdb_err", cdb_req_err, exp[32]);
      check_output("cdb_nomemreq", mem_req_valid, 0);
      check_output("cdb_clear", clear_load, (k == grant_lat));
      if (clear_load) clears++;
      cycle();
      mem_rsp_valid = 1'b0;
    end
    cdb_grant = 1'b0;
    settle();
    check_output("clear_count", clears, 1);
    check_output("done_busy", busy, 0);
    check_output("done_cdb", cdb_req_valid, 0);
  endtask

  initial begin
    logic [31:0] raddr;
    int          rlat;
    reset_ni = 1'b0;
    quiet_inputs();
    cycle();
    cycle();
    check_all_zero("reset");
    reset_ni = 1'b1;
    cycle();

    $display("[TB] aligned hit");
    apply_load(4'd3, 32'h100, 0, 2, 0, 32'hDEADBEEF);
    load_req_valid = 1'b0;

    $display("[TB] misaligned");
    apply_load(4'd5, 32'h102, 0, 0, 0, 32'h0BAD0BAD);
    load_req_valid = 1'b0;

    $display("[TB] backpressure");
    apply_load(4'd9, 32'h403, 0, 0, 3, 32'h1);
    apply_load(4'd9, 32'h400, 5, 1, 3, 32'hA5A5_5A5A);
    load_req_valid = 1'b0;

    $display("[TB] timeout");
    apply_load(4'd6, 32'h500, 0, TIMEOUT + 10, 1, 32'h5555_5555);
    load_req_valid = 1'b0;

    $display("[TB] flush in MEM_WAIT");
    load_req_valid = 1'b1; load_req_rob_addr = 4'd7; load_req_addr = 32'h200;
    cycle();
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    cycle();
    cycle();
    recover_en = 1'b1; load_req_valid = 1'b0;
    settle();
    check_output("flushwait_clear", clear_load, 0);
    cycle();
    recover_en = 1'b0;
    settle();
    check_output("drain_busy", busy, 1);
    check_output("drain_cdb", cdb_req_valid, 0);
    cycle();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234;
    settle();
    check_output("drain_rsp_cdb", cdb_req_valid, 0);
    cycle();
    mem_rsp_valid = 1'b0;
    settle();
    check_all_zero("after_drain");
    apply_load(4'd4, 32'h300, 0, 1, 0, 32'hCAFEF00D);
    load_req_valid = 1'b0;

    $display("[TB] flush in MEM_REQ, not accepted");
    load_req_valid = 1'b1; load_req_rob_addr = 4'd8; load_req_addr = 32'h600;
    cycle();
    recover_en = 1'b1; load_req_valid = 1'b0;
    settle();
    check_output("flushreq_memvalid", mem_req_valid, 1);
    cycle();
    recover_en = 1'b0;
    settle();
    check_all_zero("flushreq_idle");

    $display("[TB] flush in MEM_REQ, accepted, drain times out");
    load_req_valid = 1'b1; load_req_rob_addr = 4'd10; load_req_addr = 32'h700;
    cycle();
    recover_en = 1'b1; mem_req_ready = 1'b1; load_req_valid = 1'b0;
    cycle();
    recover_en = 1'b0; mem_req_ready = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      check_output("draintmo_busy", busy, 1);
      check_output("draintmo_cdb", cdb_req_valid, 0);
      cycle();
    end
    settle();
    check_all_zero("draintmo_idle");

    $display("[TB] flush in CDB_REQ with grant");
    load_req_valid = 1'b1; load_req_rob_addr = 4'd11; load_req_addr = 32'h3;
    cycle();
    recover_en = 1'b1; cdb_grant = 1'b1; load_req_valid = 1'b0;
    settle();
    check_output("flushcdb_valid", cdb_req_valid, 1);
    check_output("flushcdb_clear", clear_load, 0);
    cycle();
    recover_en = 1'b0; cdb_grant = 1'b0;
    settle();
    check_all_zero("flushcdb_idle");

    $display("[TB] flush in IDLE");
    recover_en = 1'b1; load_req_valid = 1'b1; load_req_addr = 32'h800;
    cycle();
    recover_en = 1'b0; load_req_valid = 1'b0;
    settle();
    check_all_zero("flushidle");

    $display("[TB] back-to-back");
    apply_load(4'd1, 32'h1000, 0, 0, 0, 32'h1111_1111);
    apply_load(4'd2, 32'h1004, 0, 0, 0, 32'h2222_2222);
    apply_load(4'd3, 32'h1008, 0, 0, 0, 32'h3333_3333);
    load_req_valid = 1'b0;

    $display("[TB] reset mid MEM_WAIT");
    load_req_valid = 1'b1; load_req_rob_addr = 4'd12; load_req_addr = 32'h900;
    cycle();
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0; load_req_valid = 1'b0;
    cycle();
    reset_ni = 1'b0;
    cycle();
    check_all_zero("midreset");
    reset_ni = 1'b1;
    cycle();

    $display("[TB] random loads");
    for (int n = 0; n < 24; n++) begin
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) raddr[1:0] = 2'b00;
      rlat = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : int'($urandom_range(0, 5));
      apply_load(4'($urandom), raddr, int'($urandom_range(0, 3)), rlat,
                 int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        load_req_valid = 1'b0;
        cycle();
      end
    end
    load_req_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
